// File: rtl/mem_byte_access_unit_pkg.sv
// Shared definitions for the MEM-stage byte access unit: FSM states and lane masks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_byte_access_unit_pkg;

  localparam int LANES = 4;

  // Byte-lane masks as emitted by the control unit.
  localparam logic [3:0] MASK_WORD = 4'b1111;
  localparam logic [3:0] MASK_BYTE = 4'b0001;
  localparam logic [3:0] MASK_NONE = 4'b0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/mem_lane_select.sv
// Finds the lowest set mask bit at or after the current lane (inclusive) or strictly after it.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is used.
module mem_lane_select
  import mem_byte_access_unit_pkg::*;
(
  input  logic [3:0] mask,
  input  logic [1:0] cur_lane,
  input  logic       incl_cur,
  output logic [1:0] next_lane,
  output logic       none_left
);

  // Descending scan so the lowest qualifying lane is the one left standing.
  always_comb begin
    next_lane = 2'd0;
    none_left = 1'b1;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (mask[i] && ((i > int'(cur_lane)) || (incl_cur && (i == int'(cur_lane))))) begin
        next_lane = i[1:0];
        none_left = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mem_byte_access_unit.sv
// Serializes word/byte loads and stores into single-byte req/ready transactions on the data RAM.
// Latency: N selected lanes take N+1 stall cycles with mem_ready high, plus one per wait cycle.
// Backpressure: mem_ready low holds the current byte (address/data stable) indefinitely; stall stays high.
module mem_byte_access_unit
  import mem_byte_access_unit_pkg::*;
#(
  parameter int MEM_ADDR_W = 10,
  parameter int DATA_W     = 32
)
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            MemRead,
  input  logic [3:0]            MemWrite,
  input  logic [31:0]           addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata,
  output logic                  stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  input  logic [7:0]            mem_rdata,
  input  logic                  mem_ready
);

  state_t                state_q;
  state_t                state_d;
  logic                  we_q;
  logic [3:0]            mask_q;
  logic [MEM_ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W-1:0]     asm_q;
  logic [DATA_W-1:0]     asm_d;
  logic [DATA_W-1:0]     rdata_q;
  logic [1:0]            lane_q;

  logic                  req;
  logic                  sel_we;
  logic [3:0]            sel_mask;
  logic [3:0]            ls_mask;
  logic [1:0]            ls_cur;
  logic                  ls_incl;
  logic [1:0]            ls_next;
  logic                  ls_none;
  logic                  hs;
  logic                  unused_addr_hi;

  // Writes win when both masks are set; the read mask is then ignored entirely.
  assign req      = (MemWrite != MASK_NONE) || (MemRead != MASK_NONE);
  assign sel_we   = (MemWrite != MASK_NONE);
  assign sel_mask = sel_we ? MemWrite : MemRead;
  assign hs       = (state_q == ACCESS) && mem_ready;

  // One finder serves both paths: first lane from the incoming mask in IDLE, advance from the latched mask in ACCESS.
  assign ls_mask  = (state_q == IDLE) ? sel_mask : mask_q;
  assign ls_cur   = (state_q == IDLE) ? 2'd0 : lane_q;
  assign ls_incl  = (state_q == IDLE);

  mem_lane_select u_lane_select (
    .mask      (ls_mask),
    .cur_lane  (ls_cur),
    .incl_cur  (ls_incl),
    .next_lane (ls_next),
    .none_left (ls_none)
  );

  // Memory port is only driven during ACCESS; everything is quiet otherwise.
  assign mem_we    = (state_q == ACCESS) && we_q;
  assign mem_addr  = (state_q == ACCESS) ? (addr_q + MEM_ADDR_W'(lane_q)) : '0;
  assign mem_wdata = (state_q == ACCESS) ? wdata_q[{lane_q, 3'b000} +: 8] : 8'h00;
  assign rdata     = rdata_q;

  // Upper effective-address bits are outside the data RAM window.
  assign unused_addr_hi = &{1'b0, addr[31:MEM_ADDR_W]};

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and handshake outputs; stall is combinational in IDLE so the pipeline freezes on detect.
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    mem_req = 1'b0;
    case (state_q)
      IDLE: begin
        stall = req;
        if (req) state_d = ACCESS;
      end
      ACCESS: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        if (hs && ls_none) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Merge the returning byte into its lane of the assembly word.
  always_comb begin
    asm_d = asm_q;
    if (hs && !we_q) asm_d[{lane_q, 3'b000} +: 8] = mem_rdata;
  end

  // Latch the instruction on detect, step lanes on each completed byte, publish load data entering DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      we_q    <= 1'b0;
      mask_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      lane_q  <= '0;
      asm_q   <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            we_q    <= sel_we;
            mask_q  <= sel_mask;
            addr_q  <= addr[MEM_ADDR_W-1:0];
            wdata_q <= wdata;
            lane_q  <= ls_next;
            asm_q   <= '0;
          end
        end
        ACCESS: begin
          if (hs) begin
            asm_q <= asm_d;
            if (!ls_none)  lane_q  <= ls_next;
            else if (!we_q) rdata_q <= asm_d;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_byte_access_unit.sv
// Directed bench for mem_byte_access_unit with a byte-wide RAM model and programmable wait states.
module tb_mem_byte_access_unit;
  import mem_byte_access_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  MemRead, MemWrite;
  logic [31:0] addr, wdata, rdata;
  logic        stall, mem_req, mem_we, mem_ready;
  logic [9:0]  mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_byte_access_unit #(.MEM_ADDR_W(10), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  // RAM model, wait-state generator, transaction log and stability monitor
  logic [7:0] mem [0:1023];
  int         wait_n = 0;
  int         wcnt = 0;
  int         cyc = 0;
  int         viol = 0;
  int         log_n = 0;
  logic       log_we   [0:255];
  logic [9:0] log_addr [0:255];
  logic [7:0] log_dat  [0:255];
  logic       pw = 1'b0;
  logic       pwe = 1'b0;
  logic [9:0] pa = '0;
  logic [7:0] pd = '0;

  assign mem_ready = mem_req && (wcnt >= wait_n);
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_req && !mem_ready) wcnt <= wcnt + 1;
    else                       wcnt <= 0;
    if (pw && mem_req && (mem_addr !== pa || mem_wdata !== pd || mem_we !== pwe)) viol <= viol + 1;
    pw  <= mem_req && !mem_ready && !reset;
    pa  <= mem_addr;
    pd  <= mem_wdata;
    pwe <= mem_we;
    if (!reset && mem_req && mem_ready) begin
      log_we[log_n[7:0]]   <= mem_we;
      log_addr[log_n[7:0]] <= mem_addr;
      log_dat[log_n[7:0]]  <= mem_wdata;
      log_n <= log_n + 1;
      if (mem_we) mem[mem_addr] <= mem_wdata;
    end
  end

  // Results of the most recent run_op
  int          op_stall, op_base, op_start, op_done;
  logic [31:0] op_rdata;
  logic        op_req_done;

  // Present one instruction in the next IDLE cycle, hold it until DONE, record what happened.
  task automatic run_op(input logic [3:0] rd, input logic [3:0] wr, input logic [31:0] a, input logic [31:0] d);
    int n;
    @(negedge clk);
    MemRead = rd; MemWrite = wr; addr = a; wdata = d;
    op_base = log_n; op_stall = 0; n = 0;
    #1;
    op_start = cyc;
    while (stall && n < 200) begin
      op_stall++;
      n++;
      @(negedge clk);
    end
    if (n >= 200) $display("FAIL op_timeout: stall still high after %0d cycles, required to drop", n);
    op_rdata = rdata; op_req_done = mem_req; op_done = cyc;
    MemRead = 4'h0; MemWrite = 4'h0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    MemRead = 4'h0; MemWrite = 4'h0; addr = '0; wdata = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests++;
      if (rdata !== 32'h0 || stall !== 1'b0 || mem_req !== 1'b0) begin
        fails++;
        $display("FAIL reset_idle cyc%0d: rdata=%h stall=%b mem_req=%b, required 0/0/0", i, rdata, stall, mem_req);
      end
      tests++;
      if (mem_we !== 1'b0 || mem_addr !== 10'h0 || mem_wdata !== 8'h0) begin
        fails++;
        $display("FAIL reset_port cyc%0d: we=%b addr=%h wdata=%h, required 0/0/0", i, mem_we, mem_addr, mem_wdata);
      end
    end
  endtask

  task automatic test_lw();
    run_op(MASK_WORD, MASK_NONE, 32'h100, 32'h0);
    tests++; if (op_stall !== 5) begin fails++; $display("FAIL lw_stall: got %0d required 5", op_stall); end
    tests++; if (op_rdata !== 32'h44332211) begin fails++; $display("FAIL lw_rdata: got %h required 44332211", op_rdata); end
    tests++; if (op_req_done !== 1'b0) begin fails++; $display("FAIL lw_done_req: got %b required 0", op_req_done); end
    tests++; if (log_n - op_base !== 4) begin fails++; $display("FAIL lw_count: got %0d required 4", log_n - op_base); end
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (log_addr[op_base + k] !== 10'(32'h100 + k) || log_we[op_base + k] !== 1'b0) begin
        fails++;
        $display("FAIL lw_txn%0d: addr=%h we=%b required addr=%h we=0", k, log_addr[op_base + k], log_we[op_base + k], 10'(32'h100 + k));
      end
    end
  endtask

  task automatic test_sb();
    run_op(MASK_NONE, MASK_BYTE, 32'h005, 32'hAABBCCDD);
    tests++; if (op_stall !== 2) begin fails++; $display("FAIL sb_stall: got %0d required 2", op_stall); end
    tests++; if (log_n - op_base !== 1) begin fails++; $display("FAIL sb_count: got %0d required 1", log_n - op_base); end
    tests++;
    if (log_we[op_base] !== 1'b1 || log_addr[op_base] !== 10'h005 || log_dat[op_base] !== 8'hDD) begin
      fails++;
      $display("FAIL sb_txn: we=%b addr=%h dat=%h required 1/005/dd", log_we[op_base], log_addr[op_base], log_dat[op_base]);
    end
    tests++; if (mem[5] !== 8'hDD) begin fails++; $display("FAIL sb_mem: got %h required dd", mem[5]); end
  endtask

  task automatic test_sw_wrap();
    logic [9:0] ea [4];
    logic [7:0] ed [4];
    int vbase;
    ea[0] = 10'h3FE; ea[1] = 10'h3FF; ea[2] = 10'h000; ea[3] = 10'h001;
    ed[0] = 8'hD4;   ed[1] = 8'hC3;   ed[2] = 8'hB2;   ed[3] = 8'hA1;
    wait_n = 2;
    vbase = viol;
    run_op(MASK_NONE, MASK_WORD, 32'h3FE, 32'hA1B2C3D4);
    wait_n = 0;
    tests++; if (op_stall !== 13) begin fails++; $display("FAIL sw_stall: got %0d required 13", op_stall); end
    tests++; if (log_n - op_base !== 4) begin fails++; $display("FAIL sw_count: got %0d required 4", log_n - op_base); end
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (log_addr[op_base + k] !== ea[k] || log_dat[op_base + k] !== ed[k] || log_we[op_base + k] !== 1'b1) begin
        fails++;
        $display("FAIL sw_txn%0d: addr=%h dat=%h we=%b required %h/%h/1", k, log_addr[op_base + k], log_dat[op_base + k], log_we[op_base + k], ea[k], ed[k]);
      end
    end
    tests++; if (viol - vbase !== 0) begin fails++; $display("FAIL sw_stable: %0d port changes during wait, required 0", viol - vbase); end
    tests++; if (mem[1] !== 8'hA1) begin fails++; $display("FAIL sw_mem_wrap: got %h required a1", mem[1]); end
  endtask

  task automatic test_priority();
    run_op(MASK_WORD, MASK_BYTE, 32'h200, 32'h1234565A);
    tests++; if (op_stall !== 2) begin fails++; $display("FAIL prio_stall: got %0d required 2", op_stall); end
    tests++; if (log_n - op_base !== 1) begin fails++; $display("FAIL prio_count: got %0d required 1", log_n - op_base); end
    tests++;
    if (log_we[op_base] !== 1'b1 || log_addr[op_base] !== 10'h200 || log_dat[op_base] !== 8'h5A) begin
      fails++;
      $display("FAIL prio_txn: we=%b addr=%h dat=%h required 1/200/5a", log_we[op_base], log_addr[op_base], log_dat[op_base]);
    end
    tests++; if (op_rdata !== 32'h44332211) begin fails++; $display("FAIL prio_rdata: got %h required 44332211", op_rdata); end
  endtask

  task automatic test_back_to_back();
    int first_done;
    run_op(MASK_NONE, MASK_NONE, 32'h0, 32'h0); // no request, returns immediately
    run_op(MASK_BYTE, MASK_NONE, 32'h101, 32'h0);
    first_done = op_done;
    tests++; if (op_rdata !== 32'h00000022) begin fails++; $display("FAIL b2b_lb_rdata: got %h required 00000022", op_rdata); end
    run_op(MASK_NONE, MASK_BYTE, 32'h300, 32'h00000077);
    tests++; if (op_start !== first_done + 1) begin fails++; $display("FAIL b2b_gap: start cycle %0d required %0d", op_start, first_done + 1); end
    tests++; if (op_stall !== 2) begin fails++; $display("FAIL b2b_stall: got %0d required 2", op_stall); end
    tests++; if (mem[10'h300] !== 8'h77) begin fails++; $display("FAIL b2b_mem: got %h required 77", mem[10'h300]); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    MemRead = MASK_WORD; MemWrite = MASK_NONE; addr = 32'h100; wdata = 32'h0;
    repeat (3) @(negedge clk);
    tests++; if (mem_addr !== 10'h102 || mem_req !== 1'b1) begin fails++; $display("FAIL mid_third_byte: addr=%h req=%b required 102/1", mem_addr, mem_req); end
    reset = 1'b1;
    MemRead = 4'h0;
    @(negedge clk);
    tests++;
    if (mem_req !== 1'b0 || stall !== 1'b0 || rdata !== 32'h0) begin
      fails++;
      $display("FAIL mid_abort: req=%b stall=%b rdata=%h required 0/0/0", mem_req, stall, rdata);
    end
    reset = 1'b0;
    run_op(MASK_BYTE, MASK_NONE, 32'h104, 32'h0);
    tests++; if (op_stall !== 2) begin fails++; $display("FAIL mid_lb_stall: got %0d required 2", op_stall); end
    tests++; if (op_rdata !== 32'h0000009C) begin fails++; $display("FAIL mid_lb_rdata: got %h required 0000009c", op_rdata); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
    mem[10'h100] <= 8'h11; mem[10'h101] <= 8'h22;
    mem[10'h102] <= 8'h33; mem[10'h103] <= 8'h44;
    mem[10'h104] <= 8'h9C;
    test_reset();
    test_lw();
    test_sb();
    test_sw_wrap();
    test_priority();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
